mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and output stage that shares one 4-to-1, 4-bit multiplexer datapath among four requesters. It picks one requester at a time and drives the mux select from the grant. It captures the selected 4-bit word into a registered output with a valid/ready handshake. Each grant is bounded to a maximum burst length so that no requester can starve the others.

## Interface
- `HOLD_MAX`, default 4: maximum beats transferred per grant; legal range 1..15.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request per requester; bit i = requester i has a word on `din_i`.
- `din0`, `din1`, `din2`, `din3` in 4 each: requester data words.
- `gnt` out 4: registered one-hot grant; all zero when idle.
- `sel` out 2: registered mux select = index of current/last grant.
- `ack` out 4: combinational one-hot beat strobe; requester i advances its data after a cycle with `ack[i]`=1.
- `out_valid` out 1: registered; `out_data` holds a valid word.
- `out_data` out 4: registered captured mux output.
- `out_ready` in 1: downstream accepts `out_data` when `out_valid` and `out_ready` are both high.

## Operation
- The state machine has two states: IDLE and GRANT. There is a 2-bit round-robin pointer `ptr` and a 4-bit beat counter `cnt`.
- IDLE:
  - If `req` != 0, the winner is the first set bit scanning `ptr`, `ptr+1`, … mod 4.
  - At the next edge: state <= GRANT, `gnt` <= onehot(winner), `sel` <= winner, `cnt` <= 0.
  - If `req` == 0, stay in IDLE.
- Accept condition: `acc` = !`out_valid` | `out_ready`.
- Beat in GRANT occurs when `req[sel]` & `acc`:
  - `ack[sel]`=1.
  - At the edge: `out_data` <= `din[sel]`, `out_valid` <= 1, `cnt` <= `cnt`+1.
- `ack` is zero in IDLE and in any GRANT cycle without a beat.
- GRANT exit, taken at the edge ending the cycle:
  - (a) `req[sel]`=0: no beat that cycle.
  - (b) a beat with `cnt`==`HOLD_MAX`-1: this is the last beat, and it still transfers.
- On exit: state <= IDLE, `gnt` <= 0, `ptr` <= `sel`+1 (mod 4, wraps 3->0), `sel` holds its value.
- Stall: in GRANT with `req[sel]`=1 but `acc`=0, the grant is held, `cnt` does not change, and there is no ack.
- `out_valid` update:
  - Set by a beat.
  - Cleared at an edge where `out_valid` & `out_ready` are high and no beat occurs.
  - With `out_valid` & `out_ready` & beat, `out_valid` stays 1 and `out_data` is replaced: back-to-back throughput of 1 word/cycle.
- `ptr` changes only on GRANT exit. A requester that raises `req` during another's grant is considered in the next IDLE cycle.
- `out_data` changes only on a beat.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate):
  - State IDLE.
  - `ptr`=0, `cnt`=0.
  - `gnt`=0000, `sel`=00, `out_valid`=0, `out_data`=0000, hence `ack`=0000.
- Reset mid-burst discards any word in `out_data` and any partial burst. The first arbitration after release starts from requester 0.
- Latency:
  - `req` sampled in IDLE at edge N gives `gnt` at N+1.
  - The first `ack` is in the cycle after edge N+1.
  - The word appears on `out_data` with `out_valid` at edge N+2.
- Each grant costs one IDLE arbitration cycle. With `out_ready`=1 held and all requesters continuously requesting, sustained throughput is `HOLD_MAX` words per `HOLD_MAX`+1 cycles.
- `ack` depends combinationally on `req`, `out_valid` and `out_ready`. Requesters must not make `req` depend combinationally on `ack`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-GRANT with `out_valid`=1 -> `gnt`=0000, `sel`=00, `out_valid`=0, `out_data`=0000 immediately, with no clock edge needed.
- **Single requester:** `req`=0010, `din1`=0xA then 0xB (advanced on ack), `out_ready`=1, `HOLD_MAX`=4 -> `gnt`=0010, `sel`=01 one cycle after `req`. `out_data` shows 0xA then 0xB on consecutive cycles.
- **Round-robin fairness:** `req`=1111 held, `out_ready`=1, `HOLD_MAX`=2 -> grant order 0,1,2,3,0. Each grant gives exactly 2 acks, separated by one IDLE cycle (`gnt`=0000).
- **Pointer wrap and skip:** after a grant to 3, `req`=0101 -> next grant goes to 0, not 2. After 0 completes, with `req`=0101 still high, the grant goes to 2.
- **Backpressure:** in GRANT with `out_valid`=1, `out_ready`=0 for 3 cycles -> `ack`=0000, `out_data` stable, `cnt` unchanged, grant held. When `out_ready` rises, beats resume and the burst still totals `HOLD_MAX`.
- **Early release:** requester 2 drops `req` after 1 of 4 beats -> GRANT exits at that edge and `ptr`=3. A simultaneous `req`=1001 is then granted to 3 before 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 x 4-bit mux among four requesters.
// Bursts are capped at HOLD_MAX beats; output is a registered valid/ready stage.
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [3:0] din3,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [3:0] ack,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] LAST = 4'(HOLD_MAX - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] ptr;
    logic [1:0] ptr_nx;
    logic [1:0] sel_nx;
    logic [1:0] win;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [3:0] gnt_nx;
    logic [3:0] od_nx;
    logic [3:0] rot;
    logic [3:0] mux_out;
    logic [7:0] dbl;
    logic       ov_nx;
    logic       acc;
    logic       beat;
    logic       last;

    always_comb begin
        mux_out = din0;
        unique case (sel)
            2'd0: mux_out = din0;
            2'd1: mux_out = din1;
            2'd2: mux_out = din2;
            2'd3: mux_out = din3;
        endcase
    end

    // rot[j] is the request of requester ptr+j, so the first set bit wins
    assign dbl = {req, req};
    assign rot = 4'(dbl >> ptr);

    always_comb begin
        win = ptr;
        priority case (1'b1)
            rot[0]:  win = ptr;
            rot[1]:  win = ptr + 2'd1;
            rot[2]:  win = ptr + 2'd2;
            rot[3]:  win = ptr + 2'd3;
            default: win = ptr;
        endcase
    end

    assign acc  = !out_valid || out_ready;
    assign beat = (state == GRANT) && req[sel] && acc;
    assign last = beat && (cnt == LAST);
    assign ack  = beat ? (4'b0001 << sel) : 4'b0000;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        cnt_nx   = cnt;
        gnt_nx   = gnt;
        unique case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nx = GRANT;
                    gnt_nx   = 4'b0001 << win;
                    sel_nx   = win;
                    cnt_nx   = 4'd0;
                end
            end
            GRANT: begin
                if (beat) begin
                    cnt_nx = cnt + 4'd1;
                end
                if (!req[sel] || last) begin
                    state_nx = IDLE;
                    gnt_nx   = 4'b0000;
                    ptr_nx   = sel + 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        ov_nx = out_valid;
        od_nx = out_data;
        if (beat) begin
            ov_nx = 1'b1;
            od_nx = mux_out;
        end else if (out_valid && out_ready) begin
            ov_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cnt       <= 4'd0;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= 4'b0000;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            sel       <= sel_nx;
            out_valid <= ov_nx;
            out_data  <= od_nx;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: HOLD_MAX=4 (u_a) and HOLD_MAX=2 (u_b).
// Requester data words advance by one after each cycle they are acked.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d [4];
    logic       out_ready;

    logic [3:0] gnt_a, ack_a, od_a;
    logic [1:0] sel_a;
    logic       ov_a;
    logic [3:0] gnt_b, ack_b, od_b;
    logic [1:0] sel_b;
    logic       ov_b;

    logic       use_b;
    int         n_run;
    int         n_fail;

    mux_rr_arbiter #(.HOLD_MAX(4)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(d[0]), .din1(d[1]), .din2(d[2]), .din3(d[3]),
        .gnt(gnt_a), .sel(sel_a), .ack(ack_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready)
    );

    mux_rr_arbiter #(.HOLD_MAX(2)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(d[0]), .din1(d[1]), .din2(d[2]), .din3(d[3]),
        .gnt(gnt_b), .sel(sel_b), .ack(ack_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // one clock: sample ack before the edge, advance acked data after it
    task automatic tick();
        logic [3:0] ap;
        @(negedge clk);
        ap = use_b ? ack_b : ack_a;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (ap[i]) d[i] = d[i] + 4'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic burst_b(input int k, input int beats);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        tick();
        chk("rr_gnt", gnt_b, oh);
        chk("rr_sel", sel_b, 8'(k));
        for (int b = 0; b < beats; b++) begin
            chk("rr_ack", ack_b, oh);
            tick();
        end
        chk("rr_idle_gnt", gnt_b, 4'b0000);
        chk("rr_idle_ack", ack_b, 4'b0000);
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        use_b     = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 4'd0;
        #2;
        chk("rst_gnt", gnt_a, 4'b0000);
        chk("rst_sel", sel_a, 2'b00);
        chk("rst_ov", ov_a, 1'b0);
        chk("rst_od", od_a, 4'b0000);
        chk("rst_ack", ack_a, 4'b0000);
        #6;
        rst_n = 1'b1;
        tick();

        // single requester, HOLD_MAX=4
        d[1] = 4'hA;
        req  = 4'b0010;
        tick();
        chk("single_gnt", gnt_a, 4'b0010);
        chk("single_sel", sel_a, 2'b01);
        chk("single_ack", ack_a, 4'b0010);
        tick();
        chk("single_ov", ov_a, 1'b1);
        chk("single_od0", od_a, 4'hA);
        chk("single_ack1", ack_a, 4'b0010);
        tick();
        chk("single_od1", od_a, 4'hB);
        tick();
        chk("single_od2", od_a, 4'hC);
        chk("single_hold", gnt_a, 4'b0010);
        tick();
        chk("single_od3", od_a, 4'hD);
        chk("single_exit", gnt_a, 4'b0000);
        chk("single_idle_ack", ack_a, 4'b0000);
        req = 4'b0000;
        tick();
        chk("single_ov_clr", ov_a, 1'b0);
        chk("single_od_keep", od_a, 4'hD);

        // fairness, wrap and skip on HOLD_MAX=2
        do_reset();
        use_b = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 4; k++) burst_b(k, 2);
        req = 4'b0101;
        burst_b(0, 2);
        burst_b(2, 2);
        req   = 4'b0000;
        use_b = 1'b0;
        tick();

        // backpressure, HOLD_MAX=4
        do_reset();
        d[0] = 4'h3;
        req  = 4'b0001;
        tick();
        chk("bp_gnt", gnt_a, 4'b0001);
        tick();
        chk("bp_od0", od_a, 4'h3);
        out_ready = 1'b0;
        #1;
        chk("bp_stall_ack", ack_a, 4'b0000);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("bp_stall_od", od_a, 4'h3);
            chk("bp_stall_gnt", gnt_a, 4'b0001);
            chk("bp_stall_ack2", ack_a, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ack", ack_a, 4'b0001);
        tick();
        chk("bp_od1", od_a, 4'h4);
        tick();
        chk("bp_od2", od_a, 4'h5);
        chk("bp_still_gnt", gnt_a, 4'b0001);
        tick();
        chk("bp_od3", od_a, 4'h6);
        chk("bp_exit", gnt_a, 4'b0000);
        req = 4'b0000;
        tick();

        // early release: ptr moves to 3
        do_reset();
        d[2] = 4'h7;
        req  = 4'b0100;
        tick();
        chk("er_gnt", gnt_a, 4'b0100);
        tick();
        chk("er_od", od_a, 4'h7);
        req = 4'b1001;
        #1;
        chk("er_noack", ack_a, 4'b0000);
        tick();
        chk("er_exit", gnt_a, 4'b0000);
        d[3] = 4'h9;
        tick();
        chk("er_next_gnt", gnt_a, 4'b1000);
        chk("er_next_sel", sel_a, 2'b11);
        tick();
        chk("er_od3", od_a, 4'h9);
        chk("er_ov", ov_a, 1'b1);

        // asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", gnt_a, 4'b0000);
        chk("ar_sel", sel_a, 2'b00);
        chk("ar_ov", ov_a, 1'b0);
        chk("ar_od", od_a, 4'b0000);
        chk("ar_ack", ack_a, 4'b0000);
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_restart", gnt_a, 4'b0001);
        req = 4'b0000;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
